// File: rtl/gpr_file.sv
// gpr_file: general register file with pending-write scoreboard, a multiply-high register
// and two registered read ports. Define GPR_BYPASS_EN to forward same-cycle writes to reads.
module gpr_file #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_a_num,
    input  logic [ADDR_W-1:0] rd_b_num,
    output logic [DATA_W-1:0] rd_a_out,
    output logic [DATA_W-1:0] rd_b_out,
    output logic              rd_a_busy,
    output logic              rd_b_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_num,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              hi_wr_en,
    input  logic [DATA_W-1:0] hi_in,
    output logic [DATA_W-1:0] hi_out,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_num
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [DATA_W-1:0]   r_hi;
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    logic [DATA_W-1:0]   r_rd_a_out_p1;
    logic [DATA_W-1:0]   r_rd_b_out_p1;
    logic                r_rd_a_busy_p1;
    logic                r_rd_b_busy_p1;

    logic [DATA_W-1:0]   w_rd_a_data;
    logic [DATA_W-1:0]   w_rd_b_data;
    logic                w_rd_a_busy;
    logic                w_rd_b_busy;

    // Reserve is applied after the write-clear so it wins on the same register.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wr_en)
            w_busy_nxt[wr_num] = 1'b0;
        if (rsv_en)
            w_busy_nxt[rsv_num] = 1'b1;
    end

`ifdef GPR_BYPASS_EN
    logic w_a_hit;
    logic w_b_hit;

    assign w_a_hit = wr_en && (wr_num == rd_a_num);
    assign w_b_hit = wr_en && (wr_num == rd_b_num);

    always_comb begin
        w_rd_a_data = w_a_hit ? wr_data : r_regs[rd_a_num];
        w_rd_b_data = w_b_hit ? wr_data : r_regs[rd_b_num];
        w_rd_a_busy = w_a_hit ? w_busy_nxt[rd_a_num] : r_busy[rd_a_num];
        w_rd_b_busy = w_b_hit ? w_busy_nxt[rd_b_num] : r_busy[rd_b_num];
    end
`else
    always_comb begin
        w_rd_a_data = r_regs[rd_a_num];
        w_rd_b_data = r_regs[rd_b_num];
        w_rd_a_busy = r_busy[rd_a_num];
        w_rd_b_busy = r_busy[rd_b_num];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
            r_hi   <= '0;
            r_busy <= '0;
        end else begin
            if (wr_en)
                r_regs[wr_num] <= wr_data;
            if (hi_wr_en)
                r_hi <= hi_in;
            r_busy <= w_busy_nxt;
        end
    end

    // Read stage: outputs hold while rd_en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_a_out_p1  <= '0;
            r_rd_b_out_p1  <= '0;
            r_rd_a_busy_p1 <= 1'b0;
            r_rd_b_busy_p1 <= 1'b0;
        end else if (rd_en) begin
            r_rd_a_out_p1  <= w_rd_a_data;
            r_rd_b_out_p1  <= w_rd_b_data;
            r_rd_a_busy_p1 <= w_rd_a_busy;
            r_rd_b_busy_p1 <= w_rd_b_busy;
        end
    end

    assign rd_a_out  = r_rd_a_out_p1;
    assign rd_b_out  = r_rd_b_out_p1;
    assign rd_a_busy = r_rd_a_busy_p1;
    assign rd_b_busy = r_rd_b_busy_p1;
    assign hi_out    = r_hi;

endmodule

// File: tb/tb_gpr_file.sv
// Bench for gpr_file: directed scenarios plus randomized traffic against a behavioural model,
// and a second 16-bit x 32-register instance for the wide configuration.
module tb_gpr_file;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_en = 1'b0;
    logic [2:0] rd_a_num = '0, rd_b_num = '0;
    logic [7:0] rd_a_out, rd_b_out;
    logic       rd_a_busy, rd_b_busy;
    logic       wr_en = 1'b0;
    logic [2:0] wr_num = '0;
    logic [7:0] wr_data = '0;
    logic       hi_wr_en = 1'b0;
    logic [7:0] hi_in = '0;
    logic [7:0] hi_out;
    logic       rsv_en = 1'b0;
    logic [2:0] rsv_num = '0;

    logic        w_rd_en = 1'b0;
    logic [4:0]  w_rd_a_num = '0, w_rd_b_num = '0;
    logic [15:0] w_rd_a_out, w_rd_b_out;
    logic        w_rd_a_busy, w_rd_b_busy;
    logic        w_wr_en = 1'b0;
    logic [4:0]  w_wr_num = '0;
    logic [15:0] w_wr_data = '0;
    logic        w_hi_wr_en = 1'b0;
    logic [15:0] w_hi_in = '0;
    logic [15:0] w_hi_out;
    logic        w_rsv_en = 1'b0;
    logic [4:0]  w_rsv_num = '0;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the default instance
    logic [7:0] m_regs [8];
    logic       m_busy [8];
    logic [7:0] m_hi, m_a, m_b;
    logic       m_ab, m_bb;

    always #5 clk = ~clk;

    gpr_file #(.DATA_W(8), .NUM_REGS(8)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en),
        .rd_a_num(rd_a_num), .rd_b_num(rd_b_num),
        .rd_a_out(rd_a_out), .rd_b_out(rd_b_out),
        .rd_a_busy(rd_a_busy), .rd_b_busy(rd_b_busy),
        .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
        .hi_wr_en(hi_wr_en), .hi_in(hi_in), .hi_out(hi_out),
        .rsv_en(rsv_en), .rsv_num(rsv_num)
    );

    gpr_file #(.DATA_W(16), .NUM_REGS(32)) dut_wide (
        .clk(clk), .rst(rst), .rd_en(w_rd_en),
        .rd_a_num(w_rd_a_num), .rd_b_num(w_rd_b_num),
        .rd_a_out(w_rd_a_out), .rd_b_out(w_rd_b_out),
        .rd_a_busy(w_rd_a_busy), .rd_b_busy(w_rd_b_busy),
        .wr_en(w_wr_en), .wr_num(w_wr_num), .wr_data(w_wr_data),
        .hi_wr_en(w_hi_wr_en), .hi_in(w_hi_in), .hi_out(w_hi_out),
        .rsv_en(w_rsv_en), .rsv_num(w_rsv_num)
    );

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_hi = '0; m_a = '0; m_b = '0; m_ab = 1'b0; m_bb = 1'b0;
    endtask

    task automatic idle();
        rd_en = 1'b0; wr_en = 1'b0; hi_wr_en = 1'b0; rsv_en = 1'b0;
    endtask

    // One clock: model follows the architectural rules at the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (rd_en) begin
                m_a = m_regs[rd_a_num]; m_ab = m_busy[rd_a_num];
                m_b = m_regs[rd_b_num]; m_bb = m_busy[rd_b_num];
`ifdef GPR_BYPASS_EN
                if (wr_en && wr_num == rd_a_num) begin
                    m_a = wr_data; m_ab = rsv_en && (rsv_num == wr_num);
                end
                if (wr_en && wr_num == rd_b_num) begin
                    m_b = wr_data; m_bb = rsv_en && (rsv_num == wr_num);
                end
`endif
            end
            if (wr_en) begin
                m_regs[wr_num] = wr_data;
                m_busy[wr_num] = 1'b0;
            end
            if (rsv_en) m_busy[rsv_num] = 1'b1;
            if (hi_wr_en) m_hi = hi_in;
        end
        #1;
    endtask

    task automatic wstep();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rd_a_out !== 8'h00 || rd_b_out !== 8'h00 || rd_a_busy !== 1'b0 || rd_b_busy !== 1'b0 || hi_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got a=%h b=%h ab=%b bb=%b hi=%h required all 0", rd_a_out, rd_b_out, rd_a_busy, rd_b_busy, hi_out);
        end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        idle(); wr_en = 1'b1; wr_num = 3'd3; wr_data = 8'hA5;
        step();
        idle(); rd_en = 1'b1; rd_a_num = 3'd3; rd_b_num = 3'd3;
        step();
        idle();
        checks++;
        if (rd_a_out !== 8'hA5 || rd_b_out !== 8'hA5 || rd_a_busy !== 1'b0 || rd_b_busy !== 1'b0) begin
            errors++;
            $display("FAIL write_read_r3 got a=%h b=%h ab=%b bb=%b required A5 A5 0 0", rd_a_out, rd_b_out, rd_a_busy, rd_b_busy);
        end
    endtask

    task automatic test_scoreboard();
        idle(); rsv_en = 1'b1; rsv_num = 3'd5;
        step();
        idle(); rd_en = 1'b1; rd_a_num = 3'd5; rd_b_num = 3'd5;
        step();
        checks++;
        if (rd_a_busy !== 1'b1 || rd_b_busy !== 1'b1) begin
            errors++;
            $display("FAIL rsv_busy got ab=%b bb=%b required 1 1", rd_a_busy, rd_b_busy);
        end
        idle(); wr_en = 1'b1; wr_num = 3'd5; wr_data = 8'h3C;
        step();
        idle(); rd_en = 1'b1; rd_a_num = 3'd5; rd_b_num = 3'd5;
        step();
        checks++;
        if (rd_a_out !== 8'h3C || rd_b_out !== 8'h3C || rd_a_busy !== 1'b0 || rd_b_busy !== 1'b0) begin
            errors++;
            $display("FAIL write_clears_busy got a=%h ab=%b bb=%b required 3C 0 0", rd_a_out, rd_a_busy, rd_b_busy);
        end
        idle(); wr_en = 1'b1; wr_num = 3'd5; wr_data = 8'h77; rsv_en = 1'b1; rsv_num = 3'd5;
        step();
        idle(); rd_en = 1'b1; rd_a_num = 3'd5; rd_b_num = 3'd5;
        step();
        idle();
        checks++;
        if (rd_a_out !== 8'h77 || rd_a_busy !== 1'b1 || rd_b_busy !== 1'b1) begin
            errors++;
            $display("FAIL rsv_wins got a=%h ab=%b bb=%b required 77 1 1", rd_a_out, rd_a_busy, rd_b_busy);
        end
    endtask

    task automatic test_same_cycle();
        logic [7:0] exp_v;
`ifdef GPR_BYPASS_EN
        exp_v = 8'h22;
`else
        exp_v = 8'h11;
`endif
        idle(); wr_en = 1'b1; wr_num = 3'd2; wr_data = 8'h11;
        step();
        wr_data = 8'h22; rd_en = 1'b1; rd_a_num = 3'd2; rd_b_num = 3'd2;
        step();
        checks++;
        if (rd_a_out !== exp_v || rd_b_out !== exp_v || rd_a_busy !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_rw got a=%h b=%h ab=%b required %h %h 0", rd_a_out, rd_b_out, rd_a_busy, exp_v, exp_v);
        end
        idle(); rd_en = 1'b1;
        step();
        idle();
        checks++;
        if (rd_a_out !== 8'h22 || rd_b_out !== 8'h22) begin
            errors++;
            $display("FAIL same_cycle_after got a=%h b=%h required 22 22", rd_a_out, rd_b_out);
        end
    endtask

    task automatic test_hi();
        idle(); hi_wr_en = 1'b1; hi_in = 8'h7E; wr_en = 1'b1; wr_num = 3'd1; wr_data = 8'h01;
        step();
        checks++;
        if (hi_out !== 8'h7E) begin
            errors++;
            $display("FAIL hi_write got %h required 7E", hi_out);
        end
        idle(); rd_en = 1'b1; rd_a_num = 3'd1; rd_b_num = 3'd1;
        step();
        checks++;
        if (rd_a_out !== 8'h01 || rd_b_out !== 8'h01) begin
            errors++;
            $display("FAIL hi_with_wr_r1 got a=%h b=%h required 01 01", rd_a_out, rd_b_out);
        end
        idle(); rd_a_num = 3'd3; rd_b_num = 3'd5; wr_en = 1'b1; wr_num = 3'd1; wr_data = 8'h99;
        hi_wr_en = 1'b1; hi_in = 8'h42;
        step();
        step();
        idle();
        checks++;
        if (rd_a_out !== 8'h01 || rd_b_out !== 8'h01 || hi_out !== 8'h42) begin
            errors++;
            $display("FAIL rd_en_low_hold got a=%h b=%h hi=%h required 01 01 42", rd_a_out, rd_b_out, hi_out);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rd_en    = ($urandom_range(0, 3) != 0);
            rd_a_num = 3'($urandom());
            rd_b_num = ($urandom_range(0, 3) == 0) ? rd_a_num : 3'($urandom());
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_num   = ($urandom_range(0, 2) == 0) ? rd_a_num : 3'($urandom());
            wr_data  = 8'($urandom());
            hi_wr_en = ($urandom_range(0, 3) == 0);
            hi_in    = 8'($urandom());
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_num  = ($urandom_range(0, 3) == 0) ? wr_num : 3'($urandom());
            step();
            checks++;
            if (rd_a_out !== m_a || rd_b_out !== m_b || rd_a_busy !== m_ab || rd_b_busy !== m_bb || hi_out !== m_hi) begin
                errors++;
                $display("FAIL random_%0d got a=%h b=%h ab=%b bb=%b hi=%h required %h %h %b %b %h",
                         n, rd_a_out, rd_b_out, rd_a_busy, rd_b_busy, hi_out, m_a, m_b, m_ab, m_bb, m_hi);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle(); wr_en = 1'b1; wr_num = 3'd6; wr_data = 8'hC3; hi_wr_en = 1'b1; hi_in = 8'hD2;
        rsv_en = 1'b1; rsv_num = 3'd7;
        step();
        idle(); rd_en = 1'b1; rd_a_num = 3'd6; rd_b_num = 3'd7;
        step();
        idle();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rd_a_out !== 8'h00 || rd_b_out !== 8'h00 || rd_a_busy !== 1'b0 || rd_b_busy !== 1'b0 || hi_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_async got a=%h b=%h ab=%b bb=%b hi=%h required all 0", rd_a_out, rd_b_out, rd_a_busy, rd_b_busy, hi_out);
        end
        wr_en = 1'b1; wr_num = 3'd4; wr_data = 8'hFF; rsv_en = 1'b1; rsv_num = 3'd4;
        hi_wr_en = 1'b1; hi_in = 8'hEE; rd_en = 1'b1;
        step();
        rst = 1'b0;
        idle();
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1; rd_a_num = 3'(i); rd_b_num = 3'(i);
            step();
            checks++;
            if (rd_a_out !== 8'h00 || rd_b_out !== 8'h00 || rd_a_busy !== 1'b0 || rd_b_busy !== 1'b0 || hi_out !== 8'h00) begin
                errors++;
                $display("FAIL reset_read_r%0d got a=%h b=%h ab=%b bb=%b hi=%h required all 0", i, rd_a_out, rd_b_out, rd_a_busy, rd_b_busy, hi_out);
            end
        end
        idle();
    endtask

    task automatic test_wide();
        logic [15:0] exp_v;
`ifdef GPR_BYPASS_EN
        exp_v = 16'h2222;
`else
        exp_v = 16'h1111;
`endif
        w_wr_en = 1'b1; w_wr_num = 5'd31; w_wr_data = 16'hBEEF;
        wstep();
        w_wr_en = 1'b0; w_rd_en = 1'b1; w_rd_a_num = 5'd31; w_rd_b_num = 5'd31;
        wstep();
        checks++;
        if (w_rd_a_out !== 16'hBEEF || w_rd_b_out !== 16'hBEEF || w_rd_a_busy !== 1'b0 || w_rd_b_busy !== 1'b0) begin
            errors++;
            $display("FAIL wide_r31 got a=%h b=%h ab=%b bb=%b required BEEF BEEF 0 0", w_rd_a_out, w_rd_b_out, w_rd_a_busy, w_rd_b_busy);
        end
        w_rd_en = 1'b0; w_rsv_en = 1'b1; w_rsv_num = 5'd5;
        wstep();
        w_rsv_en = 1'b0; w_rd_en = 1'b1; w_rd_a_num = 5'd5; w_rd_b_num = 5'd31;
        wstep();
        checks++;
        if (w_rd_a_busy !== 1'b1 || w_rd_b_busy !== 1'b0) begin
            errors++;
            $display("FAIL wide_rsv got ab=%b bb=%b required 1 0", w_rd_a_busy, w_rd_b_busy);
        end
        w_rd_en = 1'b0; w_wr_en = 1'b1; w_wr_num = 5'd2; w_wr_data = 16'h1111;
        wstep();
        w_wr_data = 16'h2222; w_rd_en = 1'b1; w_rd_a_num = 5'd2; w_rd_b_num = 5'd2;
        wstep();
        w_wr_en = 1'b0; w_rd_en = 1'b0;
        checks++;
        if (w_rd_a_out !== exp_v || w_rd_b_out !== exp_v) begin
            errors++;
            $display("FAIL wide_same_cycle got a=%h b=%h required %h", w_rd_a_out, w_rd_b_out, exp_v);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_write_read();
        test_scoreboard();
        test_same_cycle();
        test_hi();
        test_random();
        test_reset_mid();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpr_file.md
GPR_FILE -- requirements
Module: gpr_file

Interface
REQ-001 Parameter DATA_W, default 8, register and data width in bits; legal range 1..64.
REQ-002 Parameter NUM_REGS, default 8, number of general registers; SHALL be a power of two, 2..64.
REQ-003 Parameter ADDR_W, default $clog2(NUM_REGS), register-number width; not overridden by users.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rd_en  input  1  read strobe for both read ports.
REQ-007 rd_a_num, rd_b_num  input  ADDR_W  read-port A/B register numbers.
REQ-008 rd_a_out, rd_b_out  output  DATA_W  registered read data.
REQ-009 rd_a_busy, rd_b_busy  output  1  registered scoreboard bit of the register read.
REQ-010 wr_en  input  1  write strobe; wr_num input ADDR_W; wr_data input DATA_W.
REQ-011 hi_wr_en  input  1  multiply-high write strobe; hi_in input DATA_W; hi_out output DATA_W.
REQ-012 rsv_en  input  1  reserve strobe; rsv_num input ADDR_W, the register marked pending.

Function
REQ-013 Storage: NUM_REGS x DATA_W registers, one DATA_W multiply-high register, one NUM_REGS-bit scoreboard.
REQ-014 Read latency: one cycle; rd_x_out/rd_x_busy update on the edge where rd_en=1, holding their values while rd_en=0.
REQ-015 Ports A and B are independent; equal numbers on both ports return identical data and busy.
REQ-016 Write: wr_en=1 stores wr_data into register wr_num at the edge; every register number is writable, including 0.
REQ-017 hi_wr_en=1 stores hi_in at the edge; hi_out is the stored value, combinationally driven, independent of rd_en.
REQ-018 wr_en and hi_wr_en are independent; both in one cycle update both targets.
REQ-019 Scoreboard: rsv_en=1 sets bit rsv_num; wr_en=1 clears bit wr_num; same number in the same cycle -> bit ends set (reserve wins).
REQ-020 Reserve of an already-set bit leaves it set; write to a clear bit leaves it clear; no error flags.
REQ-021 Read/write same register, same cycle, without bypass: read returns pre-write data and pre-update busy bit.
REQ-022 rd_en=0 does not block writes, reserves or hi writes.

Reset
REQ-023 rst=1 immediately clears all registers, the multiply-high register, the scoreboard, rd_a_out, rd_b_out, rd_a_busy and rd_b_busy to 0, regardless of clk.
REQ-024 While rst=1, all strobes are ignored; the first edge after deassertion operates normally.
REQ-025 Reset mid-operation discards pending reservations; no write in the reset cycle takes effect.

Configuration
REQ-026 Macro GPR_BYPASS_EN, when defined, forwards a same-cycle write: wr_en=1 and wr_num equal to rd_x_num with rd_en=1 -> rd_x_out gets wr_data and rd_x_busy gets the post-update scoreboard bit.
REQ-027 Without GPR_BYPASS_EN, REQ-021 applies and no forwarding logic is built.
REQ-028 GPR_BYPASS_EN does not affect the multiply-high register, reset, or scoreboard update.

Verification
REQ-029 Reset: rst=1 pulse mid-clock after writes -> all outputs and hi_out 0 at once; reads of r0..r7 return 0x00.
REQ-030 Write 0xA5 to r3, next cycle rd_en=1, rd_a_num=3, rd_b_num=3 -> both outs 0xA5, busy 0 one cycle later.
REQ-031 rsv r5 then read r5 -> busy 1; write 0x3C to r5, read -> 0x3C, busy 0; rsv and wr r5 same cycle -> busy stays 1.
REQ-032 r2=0x11, then wr r2=0x22 with read r2 same cycle -> out 0x11 without GPR_BYPASS_EN, 0x22 with it.
REQ-033 hi_wr_en=1, hi_in=0x7E with wr_en=1 to r1=0x01 -> hi_out 0x7E, r1 reads 0x01; rd_en=0 cycles hold prior outs.
REQ-034 Run REQ-030..REQ-032 at DATA_W=16, NUM_REGS=32 with r31=0xBEEF -> read returns 0xBEEF.
